// File: rtl/mult_share_pkg.sv
// Shared types, widths and the round-robin pick function for the multiplier-sharing arbiter.
package mult_share_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned PRODUCT_W = 64;
  localparam int unsigned MAX_REQ   = 8;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;

  // Requests at or above ptr win first; if none, wrap to the lowest valid index.
  // Returns a one-hot grant (all zero when nothing is valid).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input int unsigned       ptr);
    logic [MAX_REQ-1:0] masked;
    logic [MAX_REQ-1:0] sel;
    masked = valid & ~((MAX_REQ'(1) << ptr) - MAX_REQ'(1));
    sel    = (masked != '0) ? masked : valid;
    return sel & (~sel + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/mult_share_arbiter_pipe.sv
// PIPE-stage unsigned 32x32 multiplier with a valid bit and requester tag riding alongside.
module mult_pipe
  import mult_share_pkg::*;
#(
  parameter int unsigned PIPE = 2,
  parameter int unsigned ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [ID_W-1:0]      i_id,
  input  logic [OPERAND_W-1:0] i_a,
  input  logic [OPERAND_W-1:0] i_b,
  output logic                 o_valid,
  output logic [ID_W-1:0]      o_id,
  output logic [PRODUCT_W-1:0] o_product,
  output logic                 o_any_valid
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    product_t        prod;
  } stage_t;

  stage_t            r_stage [PIPE];
  stage_t            w_in;
  logic   [PIPE-1:0] w_vld;

  // The product is formed ahead of stage 1; later stages let synthesis retime the multiplier.
  assign w_in.vld  = i_valid;
  assign w_in.id   = i_id;
  assign w_in.prod = PRODUCT_W'(i_a) * PRODUCT_W'(i_b);

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    if (s == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst)       r_stage[s] <= '0;
        else if (i_en) r_stage[s] <= w_in;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst)       r_stage[s] <= '0;
        else if (i_en) r_stage[s] <= r_stage[s-1];
      end
    end
    assign w_vld[s] = r_stage[s].vld;
  end

  assign o_valid     = r_stage[PIPE-1].vld;
  assign o_id        = r_stage[PIPE-1].id;
  assign o_product   = r_stage[PIPE-1].prod;
  assign o_any_valid = |w_vld;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ valid/ready requesters.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PIPE    = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OPERAND_W-1:0] req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0] req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [PRODUCT_W-1:0]         resp_product,
  output logic                         busy
);

  logic [ID_W-1:0]    r_ptr;
  logic [MAX_REQ-1:0] w_valid8;
  logic [MAX_REQ-1:0] w_grant8;
  logic [ID_W-1:0]    w_gidx;
  operand_t           w_a;
  operand_t           w_b;
  logic               w_advance;
  logic               w_issue;

  assign w_advance = !resp_valid || resp_ready;

  always_comb begin
    w_valid8                = '0;
    w_valid8[NUM_REQ-1:0]   = req_valid;
  end

  assign w_grant8 = rr_pick(w_valid8, 32'(r_ptr));

  always_comb begin
    w_gidx = '0;
    w_a    = '0;
    w_b    = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (w_grant8 == (MAX_REQ'(1) << i)) w_gidx = ID_W'(i);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant8 == (MAX_REQ'(1) << i)) begin
        w_a = req_a[i*OPERAND_W +: OPERAND_W];
        w_b = req_b[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  assign req_ready = (rst || !w_advance) ? '0 : w_grant8[NUM_REQ-1:0];
  assign w_issue   = |req_ready;

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= '0;
    else if (w_issue) r_ptr <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + ID_W'(1);
  end

  mult_pipe #(
    .PIPE (PIPE),
    .ID_W (ID_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_advance),
    .i_valid     (w_issue),
    .i_id        (w_gidx),
    .i_a         (w_a),
    .i_b         (w_b),
    .o_valid     (resp_valid),
    .o_id        (resp_id),
    .o_product   (resp_product),
    .o_any_valid (busy)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [IW-1:0]   resp_id;
  logic [63:0]     resp_product;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;
  logic [N-1:0] acc = '0;

  int grant_q[$];
  int grant_cyc_q[$];
  int resp_id_q[$];
  longint unsigned resp_prod_q[$];
  int resp_cyc_q[$];

  // Behavioural model: PIPE-slot conveyor that moves only when the output slot is free or taken.
  logic        m_vld [P];
  int          m_id  [P];
  logic [63:0] m_prod[P];
  int          m_ptr = 0;

  mult_share_arbiter #(
    .NUM_REQ (N),
    .PIPE    (P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (rst) return -1;
    if (m_vld[P-1] && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (pick() < 0) return '0;
    return N'(1) << pick();
  endfunction

  function automatic logic m_busy();
    logic b = 1'b0;
    for (int s = 0; s < P; s++) b = b | m_vld[s];
    return b;
  endfunction

  function automatic logic [63:0] opa(input int i);
    return {32'd0, req_a[i*32 +: 32]};
  endfunction

  function automatic logic [63:0] opb(input int i);
    return {32'd0, req_b[i*32 +: 32]};
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < P; s++) begin
        m_vld[s]  <= 1'b0;
        m_id[s]   <= 0;
        m_prod[s] <= '0;
      end
      m_ptr <= 0;
    end else if (!m_vld[P-1] || resp_ready) begin
      for (int s = P - 1; s > 0; s--) begin
        m_vld[s]  <= m_vld[s-1];
        m_id[s]   <= m_id[s-1];
        m_prod[s] <= m_prod[s-1];
      end
      m_vld[0] <= (pick() >= 0);
      if (pick() >= 0) begin
        m_id[0]   <= pick();
        m_prod[0] <= opa(pick()) * opb(pick());
        m_ptr     <= (pick() + 1) % N;
      end
    end
  end

  // Compare and log away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), 64'(exp_ready()));
    chk("resp_valid", 64'(resp_valid), 64'(m_vld[P-1]));
    chk("busy", 64'(busy), 64'(m_busy()));
    if (m_vld[P-1]) begin
      chk("resp_id", 64'(resp_id), 64'(m_id[P-1]));
      chk("resp_product", resp_product, m_prod[P-1]);
    end
    acc <= req_valid & req_ready;
    if ((req_valid & req_ready) != '0) begin
      grant_q.push_back(oh2i(req_ready));
      grant_cyc_q.push_back(cyc);
    end
    if (resp_valid && resp_ready) begin
      resp_id_q.push_back(int'(resp_id));
      resp_prod_q.push_back(resp_product);
      resp_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (mode == 0) req_valid[i] = 1'b0;
        else begin
          set_op(i, rnd_op(), rnd_op());
          if (mode == 2) req_valid[i] = ($urandom % 2) == 0;
        end
      end else if (mode == 2 && !req_valid[i] && ($urandom % 3) == 0) begin
        set_op(i, rnd_op(), rnd_op());
        req_valid[i] = 1'b1;
      end
    end
    if (mode == 2) resp_ready = ($urandom % 4) != 0;
  endtask

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc_q.delete();
    resp_id_q.delete();
    resp_prod_q.delete();
    resp_cyc_q.delete();
  endtask

  task automatic do_reset();
    mode      = 0;
    req_valid = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while ((busy || req_valid != '0) && k < max) begin
      tick();
      k++;
    end
    chk({name, "_idle_timeout"}, 64'(busy || req_valid != '0), 64'(0));
  endtask

  function automatic int qi(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  function automatic logic [63:0] qp(input int k);
    return (resp_prod_q.size() > k) ? resp_prod_q[k] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  logic [63:0] bnd_exp [3];

  initial begin
    for (int s = 0; s < P; s++) begin
      m_vld[s] = 1'b0; m_id[s] = 0; m_prod[s] = '0;
    end
    tick();
    tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_product", resp_product, 64'(0));
    rst = 1'b0;
    clear_logs();

    // Single request
    set_op(2, 32'd3, 32'd5);
    req_valid = 4'b0100;
    wait_idle("single", 20);
    chk("single_grants", 64'(grant_q.size()), 64'(1));
    chk("single_grant_id", 64'(qi(grant_q, 0)), 64'(2));
    chk("single_resp_cnt", 64'(resp_id_q.size()), 64'(1));
    chk("single_resp_id", 64'(qi(resp_id_q, 0)), 64'(2));
    chk("single_product", qp(0), 64'd15);
    chk("single_latency", 64'(qi(resp_cyc_q, 0) - qi(grant_cyc_q, 0)), 64'(P));
    chk("single_busy", 64'(busy), 64'(0));

    // All four at once
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'h10);
    req_valid = 4'hF;
    wait_idle("all4", 30);
    chk("all4_resp_cnt", 64'(resp_id_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("all4_grant", 64'(qi(grant_q, k)), 64'(k));
      chk("all4_resp_id", 64'(qi(resp_id_q, k)), 64'(k));
      chk("all4_b2b", 64'(qi(resp_cyc_q, k) - qi(resp_cyc_q, 0)), 64'(k));
    end
    chk("all4_p0", qp(0), 64'h10);
    chk("all4_p1", qp(1), 64'h20);
    chk("all4_p2", qp(2), 64'h30);
    chk("all4_p3", qp(3), 64'h40);

    // Fairness between requesters 1 and 3
    do_reset();
    mode = 1;
    set_op(1, 32'd7, 32'd9);
    set_op(3, 32'd11, 32'd13);
    req_valid = 4'b1010;
    repeat (8) tick();
    mode = 0;
    wait_idle("fair", 30);
    for (int k = 0; k < 8; k++) chk("fair_grant", 64'(qi(grant_q, k)), 64'((k % 2 == 0) ? 1 : 3));

    // Backpressure
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'h100);
    req_valid = 4'hF;
    tick();
    tick();
    repeat (5) begin
      tick();
      chk("bp_resp_valid", 64'(resp_valid), 64'(1));
      chk("bp_resp_id", 64'(resp_id), 64'(0));
      chk("bp_resp_product", resp_product, 64'h100);
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    chk("bp_grants_held", 64'(grant_q.size()), 64'(2));
    resp_ready = 1'b1;
    wait_idle("bp", 30);
    chk("bp_resp_cnt", 64'(resp_id_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("bp_grant_order", 64'(qi(grant_q, k)), 64'(k));
      chk("bp_drain_id", 64'(qi(resp_id_q, k)), 64'(k));
      chk("bp_drain_product", qp(k), 64'((k + 1) * 256));
    end

    // Boundary arithmetic
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(1, 32'h0, 32'hDEAD_BEEF);
    set_op(2, 32'h8000_0000, 32'h2);
    req_valid = 4'b0111;
    wait_idle("bnd", 30);
    bnd_exp[0] = 64'hFFFF_FFFE_0000_0001;
    bnd_exp[1] = 64'h0;
    bnd_exp[2] = 64'h1_0000_0000;
    chk("bnd_resp_cnt", 64'(resp_id_q.size()), 64'(3));
    for (int k = 0; k < 3; k++) chk("bnd_product", qp(k), bnd_exp[k]);

    // Reset mid-flight
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 5), 32'd3);
    req_valid = 4'hF;
    tick();
    tick();
    rst       = 1'b1;
    req_valid = 4'b1010;
    tick();
    chk("mrst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    clear_logs();
    wait_idle("mrst", 30);
    chk("mrst_first_grant", 64'(qi(grant_q, 0)), 64'(1));
    chk("mrst_resp_cnt", 64'(resp_id_q.size()), 64'(2));
    chk("mrst_resp_id0", 64'(qi(resp_id_q, 0)), 64'(1));
    chk("mrst_resp_id1", 64'(qi(resp_id_q, 1)), 64'(3));
    chk("mrst_product0", qp(0), 64'd18);

    // Randomized traffic with random backpressure
    do_reset();
    mode = 2;
    repeat (3000) tick();
    mode       = 0;
    resp_ready = 1'b1;
    wait_idle("rand", 100);
    chk("rand_conservation", 64'(resp_id_q.size()), 64'(grant_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined 32x32 unsigned multiplier among `NUM_REQ` requesters. Each requester presents operands with a valid/ready handshake. The block issues at most one product per cycle into the shared pipeline, tags it with the requester index, and returns the 64-bit product on a single backpressured response port. It sits between the datapath clients and the multiplier resource, replacing per-client multiplier instances.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `PIPE`, 2 — multiplier pipeline depth in cycles (1..4); the last stage is the response register.
- `ID_W`, `$clog2(NUM_REQ)` — width of the requester tag (derived; not overridden).

- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  — requester i has operands pending.
- `req_ready`  out  NUM_REQ  — requester i's operands accepted this cycle.
- `req_a`  in  NUM_REQ*32  — operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  — operand B; same packing as `req_a`.
- `resp_valid`  out  1  — `resp_product`/`resp_id` are valid.
- `resp_ready`  in  1  — consumer accepts the response.
- `resp_id`  out  ID_W  — index of the requester that issued this product.
- `resp_product`  out  64  — A*B, unsigned, full width.
- `busy`  out  1  — any pipeline stage holds a valid entry.

## Operation
- Transfer rule:
  - A request transfers when `req_valid[i] & req_ready[i]` are high at a clock edge.
  - A response transfers when `resp_valid & resp_ready` are high at a clock edge.
- `advance = !resp_valid | resp_ready`. The whole pipeline moves one stage only when `advance` is 1; otherwise every stage holds (global stall).
- Arbitration:
  - Round-robin pointer `ptr` (ID_W bits).
  - The grant goes to the first i with `req_valid[i]` set, scanning `ptr, ptr+1, … mod NUM_REQ`.
  - `req_ready[i] = grant[i] & advance`, so at most one bit is set. It is combinational from `req_valid`, `resp_valid`, `resp_ready` and `ptr`.
  - On a transfer to requester g, `ptr <= (g+1) mod NUM_REQ`. With no transfer, `ptr` holds.
- Operand and tag handling:
  - Operands are captured into stage 1 together with the tag.
  - The tag and valid bit travel alongside the product through all `PIPE` stages.
- Arithmetic:
  - Unsigned 32x32 -> 64, no truncation.
  - 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
- Requesters must hold `req_a`, `req_b` and `req_valid` stable until accepted. The block does not check this.
- An empty pipeline bubble (no grant while advancing) shifts an invalid entry forward.
- Responses leave in issue order; nothing is reordered.

## Timing
- Reset values:
  - `resp_valid=0`, `busy=0`, `ptr=0`, all stage valid bits 0.
  - `req_ready=0` while `rst=1`.
  - `resp_id` and `resp_product` reset to 0.
- Latency: accepted at edge t -> `resp_valid=1` with that product after edge t+PIPE-1, i.e. visible in the cycle following edge t+PIPE-1, provided no stall occurs.
- Throughput: one accept per cycle when `resp_ready` is held 1.
- Stall: with `resp_valid=1` and `resp_ready=0`:
  - all `req_ready` are 0;
  - all stages and `ptr` hold;
  - `resp_*` stay stable.
- Simultaneous events:
  - A response and a new issue may transfer on the same edge.
  - Multiple `req_valid` bits: only one is granted, chosen per `ptr`.
- Reset asserted mid-operation:
  - all in-flight entries are discarded and produce no response;
  - `ptr` returns to 0;
  - the first grant after reset goes to the lowest-index valid requester.
- `busy` is the OR of all stage valid bits and is registered-derived (no combinational path from inputs).

## Structure
- Package `mult_share_pkg`:
  - `OPERAND_W=32`, `PRODUCT_W=64`;
  - typedef `operand_t` (32b) and `product_t` (64b);
  - the round-robin pick function (mask-based first-one search from `ptr`).
- Sub-module `mult_pipe`:
  - `PIPE`-stage unsigned multiplier with per-stage valid and an `ID_W` tag sideband;
  - a single `en` (=`advance`) stalls all stages;
  - `clk`/`rst` as above.
- Top level holds only the arbiter, `ptr`, handshake logic and the `busy` output.

## Test plan
- Single request:
  - Stimulus: req 2, A=3, B=5, `resp_ready=1`.
  - Required: `req_ready[2]` for one cycle; `resp_id=2`, `resp_product=15` exactly PIPE cycles later; `busy` returns to 0.
- All four valid at once, `resp_ready=1`, with A=i+1, B=0x10:
  - grants in order 0,1,2,3 on consecutive cycles;
  - responses 0x10, 0x20, 0x30, 0x40 back-to-back with ids 0..3.
- Fairness:
  - Stimulus: reqs 1 and 3 held valid continuously.
  - Required: grants alternate 1,3,1,3; neither starves.
- Backpressure:
  - Stimulus: `resp_ready=0` with a response pending for 5 cycles.
  - Required: `resp_*` stable; no `req_ready`; `ptr` unchanged. On release, remaining entries drain in order with none lost or duplicated.
- Boundary arithmetic:
  - Stimulus: 0xFFFFFFFF*0xFFFFFFFF, 0*0xDEADBEEF, 0x80000000*2.
  - Required: 0xFFFFFFFE00000001, 0, 0x100000000.
- Reset mid-flight:
  - Stimulus: assert `rst` for one cycle with PIPE entries in flight.
  - Required: `resp_valid=0` and `busy=0` the next cycle; no stale responses; next grant goes to the lowest valid index.
